// File: rtl/pipe_ctrl_pkg.sv
// Shared game definitions for the pipe controller, bird controller and renderer:
// game-state encoding, screen geometry, pipe geometry, scroll timing, LFSR seed,
// and the helper that maps an LFSR byte onto a gap-top Y coordinate.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_READY    = 2'd0,
        ST_PLAY     = 2'd1,
        ST_OVER     = 2'd2,
        ST_OVER_ALT = 2'd3
    } game_state_e;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // X geometry (10-bit unsigned)
    localparam logic [9:0] H_POS      = 10'd320;  // bird column, score point
    localparam logic [9:0] SLOT_WIDTH = 10'd60;
    localparam logic [9:0] X_WRAP     = 10'd700;  // fully off-screen spawn column
    localparam logic [9:0] PIPE_GAP   = 10'd350;

    // Y geometry (9-bit, up-positive)
    localparam logic [8:0] SLOT_HEIGHT = 9'd100;
    localparam logic [8:0] LAND_HEIGHT = 9'd100;
    localparam logic [8:0] Y_MIN       = 9'd220;
    localparam logic [8:0] Y_SPAN      = 9'd200;
    localparam logic [8:0] Y_RESET     = 9'd300;

    localparam int         SPEED_DIV_DEF = 4;
    localparam logic [15:0] LFSR_SEED    = 16'hACE1;

    // A single conditional subtract folds 0..255 into 0..Y_SPAN-1; valid
    // because Y_SPAN is at least half the byte range.
    function automatic logic [8:0] new_gap_y(input logic [7:0] r);
        logic [8:0] t;
        t = {1'b0, r};
        if (t >= Y_SPAN) begin
            t = t - Y_SPAN;
        end
        return Y_MIN + t;
    endfunction

endpackage

// File: rtl/pipe_ctrl_lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting right with feedback into
// bit 15. Free-running; only rst_n reloads the seed, so the sequence position
// at spawn time depends on how long the player idles.
// Ports:
//   clk_ms  in   game clock
//   rst_n   in   async active-low reset
//   q       out  current LFSR state
module lfsr16
    import pipe_ctrl_pkg::*;
(
    input  logic        clk_ms,
    input  logic        rst_n,
    output logic [15:0] q
);

    logic fb;

    assign fb = q[0] ^ q[2] ^ q[3] ^ q[5];

    always_ff @(posedge clk_ms or negedge rst_n) begin
        if (!rst_n) begin
            q <= LFSR_SEED;
        end else begin
            q <= {fb, q[15:1]};
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipe controller: scrolls two pipes leftward one pixel every SPEED_DIV game
// clocks while in PLAY, re-spawns each at X_WRAP with a pseudo-random gap top,
// and keeps a saturating 2-digit BCD score of pipes passing the bird column.
// Pipe 2 stays parked at X_WRAP until pipe 1 has travelled PIPE_GAP pixels.
// Ports:
//   clk_ms      in   1 kHz game clock
//   rst_n       in   async active-low reset
//   state       in   game state (READY / PLAY / OVER, 3 behaves as OVER)
//   pip1_X/Y    out  pipe 1 right edge X, gap top Y
//   pip2_X/Y    out  pipe 2 right edge X, gap top Y
//   score       out  BCD {tens,ones}, saturates at 8'h99
//   pass_pulse  out  one-cycle strobe when a pipe reaches the bird column
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int SPEED_DIV = SPEED_DIV_DEF
) (
    input  logic       clk_ms,
    input  logic       rst_n,
    input  logic [1:0] state,
    output logic [9:0] pip1_X,
    output logic [8:0] pip1_Y,
    output logic [9:0] pip2_X,
    output logic [8:0] pip2_Y,
    output logic [7:0] score,
    output logic       pass_pulse
);

    localparam int DIV_W = (SPEED_DIV > 1) ? $clog2(SPEED_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SPEED_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic [9:0]       p1x_nxt, p2x_nxt;
    logic [8:0]       p1y_nxt, p2y_nxt;
    logic [7:0]       score_nxt;
    logic             armed, armed_nxt;
    logic             pulse_nxt;
    logic             step;
    logic [15:0]      lfsr_q;
    logic [8:0]       spawn_y;
    logic             unused_lfsr_hi;

    function automatic logic [7:0] bcd_inc(input logic [7:0] s);
        if (s == 8'h99) begin
            return s;
        end else if (s[3:0] == 4'd9) begin
            return {s[7:4] + 4'd1, 4'd0};
        end else begin
            return {s[7:4], s[3:0] + 4'd1};
        end
    endfunction

    lfsr16 u_lfsr (
        .clk_ms (clk_ms),
        .rst_n  (rst_n),
        .q      (lfsr_q)
    );

    // Both pipes share one spawn value; wraps cannot coincide given the spacing.
    assign spawn_y        = new_gap_y(lfsr_q[7:0]);
    assign unused_lfsr_hi = ^lfsr_q[15:8];

    always_comb begin
        div_nxt   = div_cnt;
        p1x_nxt   = pip1_X;
        p1y_nxt   = pip1_Y;
        p2x_nxt   = pip2_X;
        p2y_nxt   = pip2_Y;
        armed_nxt = armed;
        score_nxt = score;
        pulse_nxt = 1'b0;
        step      = 1'b0;

        case (state)
            ST_READY: begin
                div_nxt   = '0;
                p1x_nxt   = X_WRAP;
                p1y_nxt   = Y_RESET;
                p2x_nxt   = X_WRAP;
                p2y_nxt   = Y_RESET;
                armed_nxt = 1'b0;
                score_nxt = 8'h00;
            end
            ST_PLAY: begin
                if (div_cnt == DIV_LAST) begin
                    div_nxt = '0;
                    step    = 1'b1;
                end else begin
                    div_nxt = div_cnt + DIV_ONE;
                end
            end
            default: ;  // OVER: everything holds
        endcase

        if (step) begin
            if (pip1_X == 10'd0) begin
                p1x_nxt = X_WRAP;
                p1y_nxt = spawn_y;
            end else begin
                p1x_nxt = pip1_X - 10'd1;
            end

            if (armed) begin
                if (pip2_X == 10'd0) begin
                    p2x_nxt = X_WRAP;
                    p2y_nxt = spawn_y;
                end else begin
                    p2x_nxt = pip2_X - 10'd1;
                end
            end else if (p1x_nxt == X_WRAP - PIPE_GAP) begin
                // Pipe 2 gets its first gap now and starts moving next step.
                armed_nxt = 1'b1;
                p2y_nxt   = spawn_y;
            end

            // A parked pipe 2 sits at X_WRAP, so it can never match H_POS.
            if (p1x_nxt == H_POS || p2x_nxt == H_POS) begin
                pulse_nxt = 1'b1;
                score_nxt = bcd_inc(score);
            end
        end
    end

    always_ff @(posedge clk_ms or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            pip1_X     <= X_WRAP;
            pip1_Y     <= Y_RESET;
            pip2_X     <= X_WRAP;
            pip2_Y     <= Y_RESET;
            armed      <= 1'b0;
            score      <= 8'h00;
            pass_pulse <= 1'b0;
        end else begin
            div_cnt    <= div_nxt;
            pip1_X     <= p1x_nxt;
            pip1_Y     <= p1y_nxt;
            pip2_X     <= p2x_nxt;
            pip2_Y     <= p2y_nxt;
            armed      <= armed_nxt;
            score      <= score_nxt;
            pass_pulse <= pulse_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed timeline on the default-speed instance, with
// expected pass scores queued by the stimulus and popped by a monitor on each
// pass_pulse; a second instance at one step per clock runs long enough to reach
// and hold score 8'h99.
module tb_pipe_ctrl;

    logic       clk_ms = 1'b0;
    logic       rst_n, rst_f_n;
    logic [1:0] state, state_f;
    logic [9:0] pip1_X, pip2_X, p1x_f, p2x_f;
    logic [8:0] pip1_Y, pip2_Y, p1y_f, p2y_f;
    logic [7:0] score, score_f;
    logic       pass_pulse, pulse_f;

    always #5 clk_ms = ~clk_ms;

    pipe_ctrl dut (
        .clk_ms     (clk_ms),
        .rst_n      (rst_n),
        .state      (state),
        .pip1_X     (pip1_X),
        .pip1_Y     (pip1_Y),
        .pip2_X     (pip2_X),
        .pip2_Y     (pip2_Y),
        .score      (score),
        .pass_pulse (pass_pulse)
    );

    pipe_ctrl #(.SPEED_DIV(1)) dut_fast (
        .clk_ms     (clk_ms),
        .rst_n      (rst_f_n),
        .state      (state_f),
        .pip1_X     (p1x_f),
        .pip1_Y     (p1y_f),
        .pip2_X     (p2x_f),
        .pip2_Y     (p2y_f),
        .score      (score_f),
        .pass_pulse (pulse_f)
    );

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_ms);
    endtask

    // Reference LFSR, written in the shift-right/or form.
    logic [15:0] lfsr_m;
    always @(posedge clk_ms or negedge rst_n) begin
        if (!rst_n) lfsr_m <= 16'hACE1;
        else        lfsr_m <= (lfsr_m >> 1) | (16'(lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5]) << 15);
    end

    function automatic int exp_y(input logic [15:0] v);
        int r;
        r = int'(v[7:0]);
        if (r >= 200) r = r - 200;
        return 220 + r;
    endfunction

    // Scoreboard: expected score at each pass of the main instance.
    logic [7:0] exp_q[$];
    logic       prev_pulse = 1'b0;

    always @(negedge clk_ms) begin
        if (!rst_n) begin
            prev_pulse = 1'b0;
        end else begin
            if (pass_pulse) begin
                check("pulse_width", prev_pulse, 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_pass", 1, 0);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("score_on_pass", score, e);
                end
            end
            prev_pulse = pass_pulse;
        end
    end

    // Fast instance monitor: score after n passes is min(n,99) in BCD; every
    // new gap top stays in range.
    int         fast_pass = 0;
    logic [8:0] last_y1_f = 9'd300;
    logic [8:0] last_y2_f = 9'd300;

    always @(negedge clk_ms) begin
        if (rst_f_n) begin
            if (pulse_f) begin
                int n;
                fast_pass++;
                n = (fast_pass > 99) ? 99 : fast_pass;
                check("fast_score", score_f, ((n / 10) << 4) | (n % 10));
            end
            if (p1y_f != last_y1_f) check("fast_y1_range", (p1y_f >= 220 && p1y_f <= 419), 1);
            if (p2y_f != last_y2_f) check("fast_y2_range", (p2y_f >= 220 && p2y_f <= 419), 1);
            last_y1_f = p1y_f;
            last_y2_f = p2y_f;
        end
    end

    initial begin
        logic [15:0] cap;
        logic [9:0]  s1x, s2x;
        logic [8:0]  s1y, s2y, y2_hold;
        logic [7:0]  ssc;
        int          diffs;
        int          waited;

        rst_n = 1'b0; rst_f_n = 1'b0; state = 2'd0; state_f = 2'd0;
        cyc(3);
        check("rst_p1x", pip1_X, 700);
        check("rst_p2x", pip2_X, 700);
        check("rst_p1y", pip1_Y, 300);
        check("rst_p2y", pip2_Y, 300);
        check("rst_score", score, 0);
        check("rst_pulse", pass_pulse, 0);

        rst_n = 1'b1; rst_f_n = 1'b1; state_f = 2'd1;
        cyc(50);
        check("ready_p1x", pip1_X, 700);
        check("ready_p2x", pip2_X, 700);
        check("ready_p1y", pip1_Y, 300);
        check("ready_p2y", pip2_Y, 300);
        check("ready_score", score, 0);

        // PLAY: first step on the 4th edge
        state = 2'd1;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        cyc(3);
        check("p1x_before_step1", pip1_X, 700);
        cyc(1);
        check("p1x_step1", pip1_X, 699);
        cyc(4);
        check("p1x_step2", pip1_X, 698);
        check("p2x_parked", pip2_X, 700);

        // freeze with div_cnt == 2
        cyc(2);
        state = 2'd2;
        s1x = pip1_X; s1y = pip1_Y; s2x = pip2_X; s2y = pip2_Y; ssc = score;
        diffs = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc(1);
            if (pip1_X != s1x || pip1_Y != s1y || pip2_X != s2x || pip2_Y != s2y || score != ssc)
                diffs++;
        end
        check("over_frozen_cycles_changed", diffs, 0);
        state = 2'd1;
        cyc(1);
        check("resume_no_step_yet", pip1_X, 698);
        cyc(1);
        check("resume_step", pip1_X, 697);

        // arming step 350
        cyc(4 * 346 + 3);
        cap = lfsr_m;
        cyc(1);
        check("arm_p1x", pip1_X, 350);
        check("arm_p2x", pip2_X, 700);
        check("arm_p2y", pip2_Y, exp_y(cap));
        cyc(4);
        check("armed_p2x_moves", pip2_X, 699);
        check("armed_p1x", pip1_X, 349);

        // pipe 1 wrap at step 701
        cyc(4 * 349);
        check("p1x_at_zero", pip1_X, 0);
        check("p2x_at_p1zero", pip2_X, 350);
        y2_hold = pip2_Y;
        cyc(3);
        cap = lfsr_m;
        cyc(1);
        check("wrap_p1x", pip1_X, 700);
        check("wrap_p1y", pip1_Y, exp_y(cap));
        check("wrap_p1y_range", (pip1_Y >= 220 && pip1_Y <= 419), 1);
        check("wrap_p2x", pip2_X, 349);
        check("wrap_p2y_kept", pip2_Y, y2_hold);

        // passes 3..10, including the 09 -> 10 digit carry
        exp_q.push_back(8'h03); exp_q.push_back(8'h04); exp_q.push_back(8'h05);
        exp_q.push_back(8'h06); exp_q.push_back(8'h07); exp_q.push_back(8'h08);
        exp_q.push_back(8'h09); exp_q.push_back(8'h10);
        cyc(4 * (3540 - 701));
        check("pending_passes", exp_q.size(), 0);
        check("score_after_10", score, 8'h10);

        // OVER -> READY restores start positions
        state = 2'd2;
        cyc(5);
        state = 2'd0;
        cyc(1);
        check("ready2_p1x", pip1_X, 700);
        check("ready2_p2x", pip2_X, 700);
        check("ready2_p1y", pip1_Y, 300);
        check("ready2_p2y", pip2_Y, 300);
        check("ready2_score", score, 0);

        // async reset mid-PLAY, between clock edges
        state = 2'd1;
        exp_q.push_back(8'h01);
        cyc(4 * 381);
        check("replay_score", score, 8'h01);
        check("replay_p1x", pip1_X, 319);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_p1x", pip1_X, 700);
        check("async_p1y", pip1_Y, 300);
        check("async_p2x", pip2_X, 700);
        check("async_score", score, 0);
        state = 2'd0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        check("post_reset_p1x", pip1_X, 700);

        // wait for the fast instance to pass 101 pipes
        waited = 0;
        while (fast_pass < 101 && waited < 30000) begin
            cyc(1);
            waited++;
        end
        check("fast_reached_101_passes", (fast_pass >= 101), 1);
        check("fast_score_saturated", score_f, 8'h99);
        check("final_pending_passes", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
